// File: rtl/vga_scanout_controller.sv
// VGA scan-out engine: raster counters, linear video-memory addressing, latency-matched sync/blank
// and 10-bit DAC colour expansion. Optional VGA_SCANOUT_TEST_PATTERN_EN adds a colour-bar test_mode input.
module vga_scanout_controller #(
    parameter int H_ACTIVE                = 640,
    parameter int H_FP                    = 16,
    parameter int H_SYNC                  = 96,
    parameter int H_BP                    = 48,
    parameter int V_ACTIVE                = 480,
    parameter int V_FP                    = 10,
    parameter int V_SYNC                  = 2,
    parameter int V_BP                    = 33,
    parameter bit HS_POL                  = 1'b0,
    parameter bit VS_POL                  = 1'b0,
    parameter int SCALE_SHIFT             = 1,
    parameter int BITS_PER_COLOUR_CHANNEL = 4,
    parameter int MEM_LATENCY             = 1,
    parameter int ADDR_W                  = 17
) (
    input  logic                                   vga_clock,
    input  logic                                   resetn,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                                   test_mode,
`endif
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0]   pixel_colour,
    output logic [ADDR_W-1:0]                      memory_address,
    output logic                                   mem_rd_en,
    output logic [9:0]                             VGA_R,
    output logic [9:0]                             VGA_G,
    output logic [9:0]                             VGA_B,
    output logic                                   VGA_HS,
    output logic                                   VGA_VS,
    output logic                                   VGA_BLANK,
    output logic                                   VGA_SYNC,
    output logic                                   VGA_CLK,
    output logic                                   frame_start
);
    localparam int BPC     = BITS_PER_COLOUR_CHANNEL;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int D       = MEM_LATENCY + 2;
    localparam int DOTS_X  = H_ACTIVE >> SCALE_SHIFT;
    localparam int REPS    = (10 + BPC - 1) / BPC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       fs;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        logic       bar_en;
        logic [2:0] bar;
`endif
    } side_t;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [ADDR_W-1:0] row_base;
    logic              act0;
    side_t             side0;
    logic [D-1:1]      vld_pipe;
    side_t [D-1:1]     side_pipe;
    logic [9:0]        col_r, col_g, col_b;

    assign VGA_SYNC = 1'b1;
    assign VGA_CLK  = vga_clock;

    // Replicate the channel MSB-first and keep the top 10 bits.
    function automatic logic [9:0] expand(input logic [BPC-1:0] c);
        logic [REPS*BPC-1:0] rep;
        rep = {REPS{c}};
        return rep[REPS*BPC-1 -: 10];
    endfunction

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign act0 = (h < H_ACT) && (v < V_ACT);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BCW    = $clog2(BAR_W + 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    logic           tm_frame, tm_cur;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;

    // test_mode only takes effect at the frame-start pixel, then holds for the frame.
    assign tm_cur = (h == '0 && v == '0) ? test_mode : tm_frame;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            tm_frame <= 1'b0;
            bar_cnt  <= '0;
            bar_idx  <= '0;
        end else begin
            tm_frame <= tm_cur;
            if (h == H_LAST) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        side0    = '0;
        side0.hs = (h >= HS_BEG) && (h < HS_END);
        side0.vs = (v >= VS_BEG) && (v < VS_END);
        side0.fs = (h == '0) && (v == '0);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        side0.bar_en = tm_cur;
        side0.bar    = bar_idx;
`endif
    end

    // Row base advances once per 2^S lines, so no multiplier is needed for the dot address.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            row_base       <= '0;
            memory_address <= '0;
            mem_rd_en      <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                if (v == V_LAST)
                    row_base <= '0;
                else if ((v < V_ACT) && ((v & V_MASK) == V_MASK))
                    row_base <= row_base + ADDR_W'(DOTS_X);
            end
            memory_address <= act0 ? row_base + ADDR_W'(h >> SCALE_SHIFT) : '0;
            mem_rd_en      <= act0;
        end
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            vld_pipe  <= '0;
            side_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[D-2:1], act0};
            side_pipe <= {side_pipe[D-2:1], side0};
        end
    end

    always_comb begin
        col_r = expand(pixel_colour[3*BPC-1 -: BPC]);
        col_g = expand(pixel_colour[2*BPC-1 -: BPC]);
        col_b = expand(pixel_colour[BPC-1:0]);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        if (side_pipe[D-1].bar_en) begin
            col_r = {10{side_pipe[D-1].bar[2]}};
            col_g = {10{side_pipe[D-1].bar[1]}};
            col_b = {10{side_pipe[D-1].bar[0]}};
        end
`endif
    end

    // Final stage: pixel_colour for the pixel in stage D-1 is on the bus this cycle.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            VGA_R       <= vld_pipe[D-1] ? col_r : '0;
            VGA_G       <= vld_pipe[D-1] ? col_g : '0;
            VGA_B       <= vld_pipe[D-1] ? col_b : '0;
            VGA_HS      <= side_pipe[D-1].hs ? HS_POL : ~HS_POL;
            VGA_VS      <= side_pipe[D-1].vs ? VS_POL : ~VS_POL;
            VGA_BLANK   <= vld_pipe[D-1];
            frame_start <= side_pipe[D-1].fs;
        end
    end
endmodule

// File: tb/tb_vga_scanout_controller.sv
// Bench for vga_scanout_controller on a reduced raster; random video memory, position-based reference model.
module tb_vga_scanout_controller;
    localparam int HA = 64, HF = 4, HSY = 8, HB = 4, HT = HA + HF + HSY + HB;
    localparam int VA = 16, VF = 2, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
    localparam int S = 1, BPC = 4, LAT = 3, AW = 10;
    localparam int D = LAT + 2, FRAME = HT * VT, DX = HA >> S, DY = VA >> S;
    localparam bit HP = 1'b0, VP = 1'b1;

    logic            vga_clock = 1'b0;
    logic            resetn = 1'b0;
    logic [11:0]     pixel_colour = '0;
    logic [AW-1:0]   memory_address;
    logic            mem_rd_en;
    logic [9:0]      VGA_R, VGA_G, VGA_B;
    logic            VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK, frame_start;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic            test_mode = 1'b0;
    bit              tm_hist [8192];
`endif

    int checks = 0, errors = 0, k = 0;
    logic [11:0] vmem [DX*DY];
    typedef struct packed { logic en; logic [AW-1:0] a; } rd_t;
    rd_t rq [$];

    vga_scanout_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .SCALE_SHIFT(S),
        .BITS_PER_COLOUR_CHANNEL(BPC), .MEM_LATENCY(LAT), .ADDR_W(AW)
    ) dut (
        .vga_clock(vga_clock), .resetn(resetn),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pixel_colour(pixel_colour), .memory_address(memory_address), .mem_rd_en(mem_rd_en),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK), .frame_start(frame_start)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Top 10 bits of the channel value written out repeatedly.
    function automatic logic [9:0] dac(input logic [3:0] c);
        logic [39:0] acc;
        int n;
        acc = '0;
        n = (10 + BPC - 1) / BPC;
        for (int i = 0; i < n; i++) acc = (acc << BPC) | 40'(c);
        return 10'(acc >> (n * BPC - 10));
    endfunction

    task automatic check_reset();
        check("rst_addr", 32'(memory_address), 32'd0);
        check("rst_rden", 32'(mem_rd_en), 32'd0);
        check("rst_hs", 32'(VGA_HS), 32'(!HP));
        check("rst_vs", 32'(VGA_VS), 32'(!VP));
        check("rst_blank", 32'(VGA_BLANK), 32'd0);
        check("rst_rgb", {2'b0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
    endtask

    task automatic check_all();
        int p, pos, h, v, q, bar;
        logic act, use_bar;
        logic [11:0] c;
        logic [9:0] er, eg, eb;
        logic [31:0] ea;
        // address stage reflects the raster position one cycle earlier
        q = k - 1;
        act = 1'b0;
        ea = '0;
        if (q >= 0) begin
            pos = q % FRAME; h = pos % HT; v = pos / HT;
            act = (h < HA) && (v < VA);
            if (act) ea = 32'((v >> S) * DX + (h >> S));
        end
        check("rd_en", 32'(mem_rd_en), 32'(act));
        check("addr", 32'(memory_address), ea);
        // DAC outputs reflect the raster position D cycles earlier
        p = k - D;
        act = 1'b0; er = '0; eg = '0; eb = '0;
        h = HT; v = VT; pos = -1; use_bar = 1'b0;
        if (p >= 0) begin
            pos = p % FRAME; h = pos % HT; v = pos / HT;
            act = (h < HA) && (v < VA);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            use_bar = tm_hist[p - pos];
`endif
            if (act && use_bar) begin
                bar = h / (HA / 8);
                er = bar[2] ? 10'h3FF : 10'h0;
                eg = bar[1] ? 10'h3FF : 10'h0;
                eb = bar[0] ? 10'h3FF : 10'h0;
            end else if (act) begin
                c = vmem[(v >> S) * DX + (h >> S)];
                er = dac(c[11:8]); eg = dac(c[7:4]); eb = dac(c[3:0]);
            end
        end
        check("blank", 32'(VGA_BLANK), 32'(act));
        check("hs", 32'(VGA_HS), 32'((h >= HA + HF && h < HA + HF + HSY) ? HP : !HP));
        check("vs", 32'(VGA_VS), 32'((v >= VA + VF && v < VA + VF + VSY) ? VP : !VP));
        check("fs", 32'(frame_start), 32'(pos == 0));
        check("r", 32'(VGA_R), 32'(er));
        check("g", 32'(VGA_G), 32'(eg));
        check("b", 32'(VGA_B), 32'(eb));
        if (pos == 0 && !use_bar) begin
            check("a5f_r", 32'(VGA_R), 32'h2AA);
            check("a5f_g", 32'(VGA_G), 32'h155);
            check("a5f_b", 32'(VGA_B), 32'h3FF);
        end
        check("sync", 32'(VGA_SYNC), 32'd1);
        check("clk", 32'(VGA_CLK), 32'(vga_clock));
    endtask

    // One clock: check outputs, then play the memory's fixed-latency response.
    task automatic step();
        rd_t e;
        @(posedge vga_clock);
        #1;
        k++;
        check_all();
        rq.push_back('{en: mem_rd_en, a: memory_address});
        pixel_colour = 12'($urandom);
        if (rq.size() > LAT) begin
            e = rq.pop_front();
            if (e.en && int'(e.a) < DX * DY) pixel_colour = vmem[e.a];
        end
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        if (k == FRAME / 2) test_mode = 1'b0;
        if (k == FRAME + FRAME / 2) test_mode = 1'b1;
        tm_hist[k] = test_mode;
`endif
    endtask

    task automatic release_reset();
        @(negedge vga_clock);
        resetn = 1'b1;
        k = 0;
        rq.delete();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        test_mode = 1'b1;
        tm_hist[0] = test_mode;
`endif
    endtask

    initial begin
        for (int i = 0; i < DX * DY; i++) vmem[i] = 12'($urandom);
        vmem[0] = 12'hA5F;

        repeat (3) @(posedge vga_clock);
        #1 check_reset();
        release_reset();
        repeat (2 * FRAME + 100) step();

        // asynchronous reset mid-frame, then the scan must restart from the origin
        repeat ($urandom_range(HT * 5, FRAME - HT * 3)) step();
        #2 resetn = 1'b0;
        #1 check_reset();
        repeat (2) @(posedge vga_clock);
        #1 check_reset();
        release_reset();
        repeat (2 * FRAME + 50) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
